note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000: MasterCLK cycles per tick (10 ms at 100 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter GAP_TICKS, default 1: silent ticks inserted after each note; legal range 0..15.
REQ-003 SHALL have port MasterCLK, input, 1: single clock for all logic.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port WrEn, input, 1: score write strobe.
REQ-006 SHALL have port WrAddr, input, 4: score entry address.
REQ-007 SHALL have port WrData, input, 16: entry contents. [15:12] left note index, [11:8] right note index, [7:0] duration in ticks; duration 0 is the end marker.
REQ-008 SHALL have port Start, input, 1: one-cycle pulse; begins playback at entry 0.
REQ-009 SHALL have port Stop, input, 1: one-cycle pulse; aborts playback.
REQ-010 SHALL have port NoteData, output, 8: synthesizer note select. [7:4] left, [3:0] right; index 0 is silence.
REQ-011 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port Done, output, 1: one-cycle pulse at normal sequence end.

Function
REQ-013 SHALL hold a 16x16 score memory with synchronous write: on WrEn, mem[WrAddr] <= WrData at the clock edge; writes are accepted in every state.
REQ-014 SHALL read the score synchronously with 1-cycle latency; a same-cycle write and read of one address SHALL return the old data.
REQ-015 SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-016 IDLE: NoteData=0x00. Start SHALL move to LOAD with Addr=0 and issue a memory read.
REQ-017 LOAD (1 cycle): if duration==0, SHALL pulse Done and go to IDLE. Otherwise SHALL load NoteData={left,right} and DurCnt=duration, clear the tick prescaler, and go to PLAY.
REQ-018 PLAY: the prescaler counts 0..TICK_DIV-1; each wrap SHALL be one tick that decrements DurCnt.
REQ-019 PLAY exit: on the tick where DurCnt reaches 0, SHALL go to GAP (GAP_TICKS>0) or LOAD (GAP_TICKS==0), with Addr+1.
REQ-020 Note timing: a note of duration D SHALL hold NoteData for exactly D*TICK_DIV cycles, starting the cycle after LOAD.
REQ-021 GAP: SHALL drive NoteData=0x00 for exactly GAP_TICKS*TICK_DIV cycles, then go to LOAD.
REQ-022 Address wrap: after entry 15 finishes (including its GAP), SHALL behave as if an end marker was read: Done pulse, then IDLE.
REQ-023 Stop in any non-IDLE state SHALL force IDLE on the next edge with NoteData=0x00 and no Done pulse.
REQ-024 Start while Busy SHALL be ignored; simultaneous Start and Stop SHALL resolve Stop-wins.
REQ-025 Note indices SHALL pass unmodified; the sequencer performs no range check on note values.

Reset
REQ-026 Reset low at a clock edge SHALL force IDLE, NoteData=0x00, Busy=0, Done=0, Addr=0, DurCnt=0, prescaler=0, overriding any activity mid-note.
REQ-027 Reset SHALL NOT clear score memory contents.

Configuration
REQ-028 With macro NOTE_SEQ_LOOP_EN defined, SHALL add input Loop (1 bit).
REQ-029 With NOTE_SEQ_LOOP_EN defined and Loop high at an end condition (REQ-017/REQ-022), SHALL pulse Done, set Addr=0, and go to LOAD instead of IDLE.
REQ-030 With NOTE_SEQ_LOOP_EN undefined, Loop SHALL be absent and the end condition SHALL always return to IDLE.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-031 mem[0]=0x1D02, mem[1]=0x0000, Start -> NoteData=0x1D for 8 cycles, 0x00 gap for 4 cycles, Done pulse, Busy low.
REQ-032 mem[0]=0x0000, Start -> Done pulses 2 cycles after Start, NoteData stays 0x00.
REQ-033 All 16 entries 0x3401, Start -> 16 notes of 4 cycles each, every note followed by a 4-cycle gap, then Done after entry 15.
REQ-034 Stop mid-note, 3 cycles into PLAY -> NoteData=0x00 and Busy=0 next cycle, no Done; Start+Stop same cycle from IDLE -> stays IDLE.
REQ-035 Reset low during PLAY -> all outputs at reset values next edge; a second Start replays the unchanged mem[0].
REQ-036 NOTE_SEQ_LOOP_EN defined, Loop=1, mem[0]=0x5501, mem[1]=0x0000 -> 0x55 repeats indefinitely with a Done pulse each pass; Loop=0 -> single pass.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: plays a 16-entry score of two-voice notes, one entry at a time.
// Each entry holds {left[3:0], right[3:0], duration[7:0]}; duration 0 ends the score.
// Optional build macro NOTE_SEQ_LOOP_EN adds a Loop input that restarts playback
// from entry 0 at the end of the score instead of returning to IDLE.
module note_sequencer #(
    parameter int TICK_DIV  = 1000000,
    parameter int GAP_TICKS = 1
) (
    input  logic        MasterCLK,
    input  logic        Reset,
    input  logic        WrEn,
    input  logic [3:0]  WrAddr,
    input  logic [15:0] WrData,
    input  logic        Start,
    input  logic        Stop,
`ifdef NOTE_SEQ_LOOP_EN
    input  logic        Loop,
`endif
    output logic [7:0]  NoteData,
    output logic        Busy,
    output logic        Done
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    logic [15:0]   score_mem [0:15];
    logic [15:0]   rd_data_reg;

    state_t        state_reg, state_next;
    // bit 4 marks "past entry 15", which is treated like reading an end marker
    logic [4:0]    addr_reg, addr_next;
    logic [7:0]    dur_cnt_reg, dur_cnt_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    note_reg, note_next;
    logic          done_reg, done_next;

    logic          tick;
    logic          end_hit;
    logic          loop_en;

`ifdef NOTE_SEQ_LOOP_EN
    assign loop_en = Loop;
`else
    assign loop_en = 1'b0;
`endif

    // Score RAM: writes in any state; read address follows the next address so
    // the entry for a LOAD is already registered when LOAD is entered.
    always_ff @(posedge MasterCLK) begin
        if (WrEn) begin
            score_mem[WrAddr] <= WrData;
        end
        rd_data_reg <= score_mem[addr_next[3:0]];
    end

    // Sequencer state register with synchronous active-low reset.
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            dur_cnt_reg <= '0;
            presc_reg   <= '0;
            note_reg    <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            dur_cnt_reg <= dur_cnt_next;
            presc_reg   <= presc_next;
            note_reg    <= note_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic: tick prescaler, duration/gap countdown, entry stepping.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        dur_cnt_next = dur_cnt_reg;
        presc_next   = presc_reg;
        note_next    = note_reg;
        done_next    = 1'b0;

        tick    = (presc_reg == PRESC_LAST);
        end_hit = addr_reg[4] || (rd_data_reg[7:0] == 8'd0);

        case (state_reg)
            IDLE: begin
                if (Start && !Stop) begin
                    state_next = LOAD;
                    addr_next  = '0;
                end
            end
            LOAD: begin
                if (end_hit) begin
                    done_next  = 1'b1;
                    addr_next  = '0;
                    state_next = loop_en ? LOAD : IDLE;
                end else begin
                    note_next    = rd_data_reg[15:8];
                    dur_cnt_next = rd_data_reg[7:0];
                    presc_next   = '0;
                    state_next   = PLAY;
                end
            end
            PLAY: begin
                presc_next = tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    dur_cnt_next = dur_cnt_reg - 8'd1;
                    if (dur_cnt_reg == 8'd1) begin
                        note_next = '0;
                        addr_next = addr_reg + 5'd1;
                        if (GAP_TICKS > 0) begin
                            // gap length reuses the duration counter
                            state_next   = GAP;
                            dur_cnt_next = 8'(GAP_TICKS);
                        end else begin
                            state_next = LOAD;
                        end
                    end
                end
            end
            GAP: begin
                presc_next = tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    dur_cnt_next = dur_cnt_reg - 8'd1;
                    if (dur_cnt_reg == 8'd1) begin
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Stop aborts silently from any active state and beats a same-cycle Start.
        if (Stop && (state_reg != IDLE)) begin
            state_next   = IDLE;
            addr_next    = '0;
            dur_cnt_next = '0;
            presc_next   = '0;
            note_next    = '0;
            done_next    = 1'b0;
        end
    end

    assign NoteData = note_reg;
    assign Busy     = (state_reg != IDLE);
    assign Done     = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer (TICK_DIV=4, GAP_TICKS=1). Expected output traces
// are built per cycle from the score contents; define NOTE_SEQ_LOOP_EN to add
// the looping scenario.
module tb_note_sequencer;

    localparam int TD = 4;
    localparam int GT = 1;

    logic        MasterCLK = 1'b0;
    logic        Reset     = 1'b0;
    logic        WrEn      = 1'b0;
    logic [3:0]  WrAddr    = '0;
    logic [15:0] WrData    = '0;
    logic        Start     = 1'b0;
    logic        Stop      = 1'b0;
    logic [7:0]  NoteData;
    logic        Busy;
    logic        Done;
`ifdef NOTE_SEQ_LOOP_EN
    logic        Loop      = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_mem [16];
    logic [9:0]  exp_q [$];     // per-cycle {NoteData, Busy, Done}
    bit          start_noise = 1'b0;

    note_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .MasterCLK (MasterCLK),
        .Reset     (Reset),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Start     (Start),
        .Stop      (Stop),
`ifdef NOTE_SEQ_LOOP_EN
        .Loop      (Loop),
`endif
        .NoteData  (NoteData),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 MasterCLK = ~MasterCLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic void push_exp(input logic [7:0] note, input bit busy, input bit done, input int count);
        for (int k = 0; k < count; k++) begin
            exp_q.push_back({note, busy, done});
        end
    endfunction

    // One walk through the score starting at its first LOAD cycle; stops at the
    // LOAD cycle that sees the end condition (marker or running past entry 15).
    function automatic void build_pass(input bit first_done);
        bit done_flag = first_done;
        int dur;
        for (int i = 0; i < 16; i++) begin
            push_exp(8'h00, 1'b1, done_flag, 1);
            done_flag = 1'b0;
            dur = int'(model_mem[i][7:0]);
            if (dur == 0) begin
                return;
            end
            push_exp(model_mem[i][15:8], 1'b1, 1'b0, dur * TD);
            push_exp(8'h00, 1'b1, 1'b0, GT * TD);
        end
        push_exp(8'h00, 1'b1, 1'b0, 1);
    endfunction

    function automatic void finish_idle();
        push_exp(8'h00, 1'b0, 1'b1, 1);
        push_exp(8'h00, 1'b0, 1'b0, 3);
    endfunction

    task automatic load_score();
        for (int i = 0; i < 16; i++) begin
            WrEn   = 1'b1;
            WrAddr = 4'(i);
            WrData = model_mem[i];
            @(posedge MasterCLK); #1;
        end
        WrEn = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 16'h0000;
        end
    endtask

    // Consumes the expected trace one cycle at a time, sampling after each edge.
    task automatic run_check(input string tag, input int limit);
        int n = 0;
        logic [9:0] want;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge MasterCLK); #1;
            want = exp_q.pop_front();
            check_value($sformatf("%s[%0d]", tag, n), {22'd0, NoteData, Busy, Done}, {22'd0, want});
            Start = start_noise && want[1] && ($urandom_range(0, 7) == 0);
            n++;
        end
        Start = 1'b0;
        $display("run %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge MasterCLK);
        #1;
        check_value("reset", {24'd0, NoteData, Busy, Done}, 32'd0);
        Reset = 1'b1;

        // single note then end marker
        clear_model();
        model_mem[0] = 16'h1D02;
        load_score();
        build_pass(1'b0);
        finish_idle();
        Start = 1'b1;
        run_check("single_note", 1000);

        // empty score
        clear_model();
        load_score();
        build_pass(1'b0);
        finish_idle();
        Start = 1'b1;
        run_check("empty", 1000);

        // full score, wraps past entry 15
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h3401;
        load_score();
        build_pass(1'b0);
        finish_idle();
        Start = 1'b1;
        run_check("full_wrap", 2000);

        // Stop three cycles into PLAY
        clear_model();
        model_mem[0] = 16'h2602;
        load_score();
        build_pass(1'b0);
        Start = 1'b1;
        run_check("pre_stop", 4);
        exp_q.delete();
        Stop = 1'b1;
        @(posedge MasterCLK); #1;
        Stop = 1'b0;
        check_value("stop", {24'd0, NoteData, Busy, Done}, 32'd0);
        push_exp(8'h00, 1'b0, 1'b0, 4);
        run_check("after_stop", 10);

        // Start and Stop together from IDLE
        Start = 1'b1;
        Stop  = 1'b1;
        @(posedge MasterCLK); #1;
        Start = 1'b0;
        Stop  = 1'b0;
        check_value("start_stop", {24'd0, NoteData, Busy, Done}, 32'd0);
        push_exp(8'h00, 1'b0, 1'b0, 3);
        run_check("start_stop_idle", 10);

        // Reset during PLAY, then replay the retained score
        clear_model();
        model_mem[0] = 16'h7A03;
        load_score();
        build_pass(1'b0);
        Start = 1'b1;
        run_check("pre_reset", 6);
        exp_q.delete();
        Reset = 1'b0;
        @(posedge MasterCLK); #1;
        Reset = 1'b1;
        check_value("mid_reset", {24'd0, NoteData, Busy, Done}, 32'd0);
        build_pass(1'b0);
        finish_idle();
        Start = 1'b1;
        run_check("replay", 1000);

        // randomized scores with stray Start pulses while busy
        start_noise = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                model_mem[i][15:8] = 8'($urandom);
                model_mem[i][7:0]  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            end
            load_score();
            build_pass(1'b0);
            finish_idle();
            Start = 1'b1;
            run_check($sformatf("random%0d", r), 2000);
        end
        start_noise = 1'b0;

`ifdef NOTE_SEQ_LOOP_EN
        // looping playback: three passes, then drop Loop for a normal end
        clear_model();
        model_mem[0] = 16'h5501;
        load_score();
        Loop = 1'b1;
        build_pass(1'b0);
        build_pass(1'b1);
        build_pass(1'b1);
        Start = 1'b1;
        run_check("loop", 1000);
        Loop = 1'b0;
        finish_idle();
        run_check("loop_end", 100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
